// File: rtl/chip_model_pkg.sv
// Shared constants for the 74x161 socket model: socket pin numbers and the
// defect-injection selector.
package chip_model_pkg;

    localparam int PIN_CLR_N  = 1;
    localparam int PIN_CLK    = 2;
    localparam int PIN_A      = 3;
    localparam int PIN_B      = 4;
    localparam int PIN_C      = 5;
    localparam int PIN_D      = 6;
    localparam int PIN_ENP    = 7;
    localparam int PIN_GND    = 8;
    localparam int PIN_LOAD_N = 9;
    localparam int PIN_ENT    = 10;
    localparam int PIN_QD     = 11;
    localparam int PIN_QC     = 12;
    localparam int PIN_QB     = 13;
    localparam int PIN_QA     = 14;
    localparam int PIN_RCO    = 15;
    localparam int PIN_VCC    = 16;

    typedef enum logic [1:0] {
        NONE      = 2'b00,
        QA_STUCK0 = 2'b01,
        RCO_INV   = 2'b10,
        ABSENT    = 2'b11
    } fault_t;

endpackage

// File: rtl/pin_sync.sv
// Multi-stage synchronizer for all 16 socket pins, plus rising-edge detection
// on one selected pin.
module pin_sync #(
    parameter int STAGES   = 2,
    parameter int RISE_PIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:1] din,
    output logic [16:1] dout,
    output logic        rise
);

    localparam int WW = $clog2(STAGES + 2);
    localparam logic [WW-1:0] WARM_DONE = WW'(STAGES + 1);

    logic [16:1]   stage [STAGES];
    logic          prev;
    logic [WW-1:0] warm;

    // Edges stay suppressed until the chain has refilled after reset and prev
    // holds a real pin sample, so a pin held high across reset is not a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
            prev <= 1'b0;
            warm <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            prev <= dout[RISE_PIN];
            if (warm != WARM_DONE) begin
                warm <= warm + 1'b1;
            end
        end
    end

    assign dout = stage[STAGES-1];
    assign rise = dout[RISE_PIN] & ~prev & (warm == WARM_DONE);

endmodule

// File: rtl/chip_socket_model.sv
// Behavioural stand-in for a 74x161 counter sitting in a test socket, with
// selectable defects for exercising the chip checker.
module chip_socket_model
    import chip_model_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [16:1] Pin_in,
    output logic [16:1] Pin_out,
    output logic [16:1] Pin_oe,
    input  logic [1:0]  FaultSel,
    output logic [3:0]  Count
);

    logic [16:1] pins;
    logic        clk_rise;
    logic [3:0]  count;
    logic        powered;
    logic        rco;
    fault_t      fault;
    logic        unused_pins;

    pin_sync #(
        .STAGES  (SYNC_STAGES),
        .RISE_PIN(PIN_CLK)
    ) u_sync (
        .clk  (Clk),
        .reset(Reset),
        .din  (Pin_in),
        .dout (pins),
        .rise (clk_rise)
    );

    assign powered = pins[PIN_VCC];
    assign fault   = fault_t'(FaultSel);
    assign rco     = pins[PIN_ENT] & (count == 4'hF);

    // Clear does not wait for a socket clock edge; power loss beats everything.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= 4'h0;
        end else if (!powered || !pins[PIN_CLR_N]) begin
            count <= 4'h0;
        end else if (clk_rise) begin
            if (!pins[PIN_LOAD_N]) begin
                count <= {pins[PIN_D], pins[PIN_C], pins[PIN_B], pins[PIN_A]};
            end else if (pins[PIN_ENP] && pins[PIN_ENT]) begin
                count <= count + 4'd1;
            end
        end
    end

    always_comb begin
        Pin_out = '0;
        Pin_oe  = '0;
        if (powered) begin
            Pin_out[PIN_QA]  = count[0] & (fault != QA_STUCK0);
            Pin_out[PIN_QB]  = count[1];
            Pin_out[PIN_QC]  = count[2];
            Pin_out[PIN_QD]  = count[3];
            Pin_out[PIN_RCO] = rco ^ (fault == RCO_INV);
            if (fault != ABSENT) begin
                Pin_oe[PIN_RCO:PIN_QD] = '1;
            end
        end
    end

    assign Count = count;

    // Output pins read back from the socket and the ground/clock levels carry
    // no information the counter needs.
    assign unused_pins = ^{pins[PIN_GND], pins[PIN_CLK], pins[PIN_RCO:PIN_QD]};

endmodule

// File: tb/tb_chip_socket_model.sv
// Directed self-checking bench for chip_socket_model: counting, load, clear,
// enable hold, defect injection, reset and power loss.
module tb_chip_socket_model;

    logic        Clk;
    logic        Reset;
    logic [16:1] Pin_in;
    logic [16:1] Pin_out;
    logic [16:1] Pin_oe;
    logic [1:0]  FaultSel;
    logic [3:0]  Count;

    logic       vcc, clrN, clkPin, enp, loadN, ent;
    logic [3:0] data;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] OE_ON = 16'h7C00;

    assign Pin_in = {vcc, 5'b00000, ent, loadN, 1'b0, enp, data, clkPin, clrN};

    chip_socket_model #(.SYNC_STAGES(2)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Pin_in  (Pin_in),
        .Pin_out (Pin_out),
        .Pin_oe  (Pin_oe),
        .FaultSel(FaultSel),
        .Count   (Count)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Advance n Clk cycles and land 1 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] expOut(input logic [3:0] c, input logic r);
        logic [15:0] v;
        v     = '0;
        v[10] = c[3];
        v[11] = c[2];
        v[12] = c[1];
        v[13] = c[0];
        v[14] = r;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input logic [3:0] expected);
        checkOutput(tag, {12'h000, Count}, {12'h000, expected});
    endtask

    // One socket clock pulse: two Clk cycles high, two low.
    task automatic applyStimulus();
        clkPin = 1'b1;
        tick(2);
        clkPin = 1'b0;
        tick(2);
    endtask

    initial begin
        Reset = 1'b1;
        FaultSel = 2'b00;
        vcc = 1'b0; clrN = 1'b0; clkPin = 1'b0; enp = 1'b0;
        loadN = 1'b0; ent = 1'b0; data = 4'h0;
        tick(3);
        checkCount("reset_count", 4'h0);
        checkOutput("reset_oe", Pin_oe, 16'h0000);
        checkOutput("reset_out", Pin_out, 16'h0000);

        Reset = 1'b0;
        vcc = 1'b1; clrN = 1'b1; loadN = 1'b1; enp = 1'b1; ent = 1'b1;
        tick(5);
        checkOutput("powered_oe", Pin_oe, OE_ON);

        $display("[TB] Test 1: free count and wrap");
        clkPin = 1'b1;
        tick(2);
        checkCount("latency_before", 4'h0);
        tick(1);
        checkCount("latency_at3", 4'h1);
        clkPin = 1'b0;
        tick(3);
        for (int i = 2; i <= 15; i++) begin
            applyStimulus();
            checkCount("count_step", 4'(i));
        end
        checkOutput("rco_at15", Pin_out, expOut(4'hF, 1'b1));
        applyStimulus();
        checkCount("wrap_to0", 4'h0);
        applyStimulus();
        checkCount("wrap_to1", 4'h1);
        checkOutput("out_at1", Pin_out, expOut(4'h1, 1'b0));

        $display("[TB] Test 2: parallel load");
        loadN = 1'b0; data = 4'b1010;
        tick(3);
        applyStimulus();
        checkCount("load_1010", 4'hA);
        checkOutput("load_pins", Pin_out, expOut(4'hA, 1'b0));
        loadN = 1'b1;

        $display("[TB] Test 3: clear beats load");
        data = 4'b0111;
        clrN = 1'b0; loadN = 1'b0;
        tick(3);
        checkCount("clear_no_edge", 4'h0);
        applyStimulus();
        checkCount("clear_with_edge", 4'h0);
        clrN = 1'b1; loadN = 1'b1;
        tick(3);

        $display("[TB] Test 4: ENT low holds");
        loadN = 1'b0; data = 4'hF;
        tick(3);
        applyStimulus();
        loadN = 1'b1;
        tick(3);
        checkCount("load_15", 4'hF);
        checkOutput("rco_high", Pin_out, expOut(4'hF, 1'b1));
        ent = 1'b0;
        tick(3);
        checkOutput("rco_ent_low", Pin_out, expOut(4'hF, 1'b0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkCount("hold_ent_low", 4'hF);
        end
        ent = 1'b1;
        tick(3);

        $display("[TB] Test 5: fault injection");
        FaultSel = 2'b01;
        tick(1);
        checkOutput("fault_qa_stuck", Pin_out, expOut(4'hE, 1'b1));
        checkCount("fault_qa_count", 4'hF);
        FaultSel = 2'b10;
        tick(1);
        checkOutput("fault_rco_inv", Pin_out, expOut(4'hF, 1'b0));
        FaultSel = 2'b11;
        tick(1);
        checkOutput("fault_absent_oe", Pin_oe, 16'h0000);
        applyStimulus();
        checkCount("absent_counts", 4'h0);
        FaultSel = 2'b00;
        tick(1);
        checkOutput("fault_cleared_oe", Pin_oe, OE_ON);

        $display("[TB] Test 6: reset and power loss");
        for (int i = 0; i < 5; i++) applyStimulus();
        checkCount("five_counts", 4'h5);
        clkPin = 1'b1;
        tick(2);
        Reset = 1'b1;
        #1;
        checkCount("async_reset", 4'h0);
        checkOutput("reset_oe_mid", Pin_oe, 16'h0000);
        tick(2);
        Reset = 1'b0;
        tick(6);
        checkCount("no_edge_after_reset", 4'h0);
        clkPin = 1'b0;
        tick(3);
        applyStimulus();
        checkCount("fresh_rise", 4'h1);
        vcc = 1'b0;
        tick(3);
        checkCount("unpowered_count", 4'h0);
        checkOutput("unpowered_oe", Pin_oe, 16'h0000);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkCount("unpowered_clocking", 4'h0);
        vcc = 1'b1;
        tick(3);
        checkCount("repowered_hold", 4'h0);
        checkOutput("repowered_oe", Pin_oe, OE_ON);
        applyStimulus();
        checkCount("repowered_count", 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
